// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between mem_port_arbiter, its two requesters and the data memory.
//   fetch  : i_if_req, i_if_addr            -> o_if_rdata, o_if_ack
//   data   : i_d_req, i_d_we, i_d_addr,
//            i_d_wdata, i_d_size            -> o_d_rdata, o_d_ack
//   memory : o_mem_re, o_mem_we, o_mem_addr,
//            o_mem_wdata, o_mem_size        <- i_mem_rdata, i_mem_rready, i_mem_wready
//   status : o_busy
// slave  = arbiter side, master = requester/memory side.
interface mem_port_arbiter_if;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic [31:0] o_if_rdata;
  logic        o_if_ack;

  logic        i_d_req;
  logic        i_d_we;
  logic [31:0] i_d_addr;
  logic [31:0] i_d_wdata;
  logic [1:0]  i_d_size;
  logic [31:0] o_d_rdata;
  logic        o_d_ack;

  logic        o_mem_re;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [1:0]  o_mem_size;
  logic [31:0] i_mem_rdata;
  logic        i_mem_rready;
  logic        i_mem_wready;

  logic        o_busy;

  modport slave (
    input  i_if_req, i_if_addr,
    input  i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_size,
    input  i_mem_rdata, i_mem_rready, i_mem_wready,
    output o_if_rdata, o_if_ack,
    output o_d_rdata, o_d_ack,
    output o_mem_re, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_size,
    output o_busy
  );

  modport master (
    output i_if_req, i_if_addr,
    output i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_size,
    output i_mem_rdata, i_mem_rready, i_mem_wready,
    input  o_if_rdata, o_if_ack,
    input  o_d_rdata, o_d_ack,
    input  o_mem_re, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_size,
    input  o_busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported data memory between the fetch port (word reads) and
// the data port (byte/half/word reads and writes). One transaction at a time;
// the data port wins unless fetch has waited through STARVE_LIMIT data grants.
// Ports:
//   i_clk   : clock, rising edge
//   i_rstn  : asynchronous active-low reset
//   bus     : mem_port_arbiter_if.slave (fetch, data, memory and busy signals)
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  mem_port_arbiter_if.slave   bus
);

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = 2;
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]    SIZE_WORD = SW'(2);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
  logic [SW-1:0]     mem_size_q, mem_size_d;
  logic [DW-1:0]     if_rdata_q, if_rdata_d;
  logic [DW-1:0]     d_rdata_q, d_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  starve_q, starve_d;

  logic              if_req_v;
  logic              d_req_v;
  logic              d_done;

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= IDLE;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      busy_q      <= busy_d;
      starve_q    <= starve_d;
    end
  end

  // A port being acked this cycle still holds its request; mask it out.
  assign if_req_v = bus.i_if_req & ~if_ack_q;
  assign d_req_v  = bus.i_d_req  & ~d_ack_q;

  // Only the ready matching the granted direction completes a data transfer.
  assign d_done = mem_we_q ? bus.i_mem_wready : bus.i_mem_rready;

  // Arbitration, transfer sequencing and output next-values
  always_comb begin
    state_d     = state_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_size_d  = mem_size_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    starve_d    = starve_q;

    unique case (state_q)
      IDLE: begin
        if (!bus.i_if_req) begin
          starve_d = '0;
        end
        // The ack cycle never issues a grant, which spaces grants 3 cycles
        // apart and lets a requester that was just served withdraw.
        if (!(if_ack_q || d_ack_q)) begin
          if (d_req_v && (!if_req_v || starve_q != CNT_MAX)) begin
            state_d     = GNT_D;
            mem_re_d    = ~bus.i_d_we;
            mem_we_d    = bus.i_d_we;
            mem_addr_d  = bus.i_d_addr;
            mem_wdata_d = bus.i_d_wdata;
            mem_size_d  = bus.i_d_size;
            // starve_q < CNT_MAX here whenever fetch waits, so this saturates.
            if (if_req_v) begin
              starve_d = starve_q + CNT_W'(1);
            end
          end else if (if_req_v) begin
            state_d    = GNT_IF;
            mem_re_d   = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = bus.i_if_addr;
            mem_size_d = SIZE_WORD;
            starve_d   = '0;
          end
        end
      end

      GNT_IF: begin
        if (bus.i_mem_rready) begin
          if_rdata_d = bus.i_mem_rdata;
          if_ack_d   = 1'b1;
          mem_re_d   = 1'b0;
          mem_we_d   = 1'b0;
          state_d    = IDLE;
        end
      end

      GNT_D: begin
        if (d_done) begin
          if (!mem_we_q) begin
            d_rdata_d = bus.i_mem_rdata;
          end
          d_ack_d  = 1'b1;
          mem_re_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        mem_re_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.o_mem_re    = mem_re_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_mem_size  = mem_size_q;
  assign bus.o_if_rdata  = if_rdata_q;
  assign bus.o_if_ack    = if_ack_q;
  assign bus.o_d_rdata   = d_rdata_q;
  assign bus.o_d_ack     = d_ack_q;
  assign bus.o_busy      = busy_q;

  // Requesters must hold their request until acked.
  a_if_req_held: assert property (@(posedge i_clk) disable iff (!i_rstn)
    (state_q == GNT_IF) |-> bus.i_if_req);
  a_d_req_held: assert property (@(posedge i_clk) disable iff (!i_rstn)
    (state_q == GNT_D) |-> bus.i_d_req);
  a_re_we_excl: assert property (@(posedge i_clk) disable iff (!i_rstn)
    !(mem_re_q && mem_we_q));

endmodule
